camera: RTL and testbench

//  MIPI CSI-2 D-PHY receiver core: deserialises 1-4 DDR data lanes, finds the per-lane sync byte,
//  and parses the CSI-2 packet header (VC, DT, WC, ECC). Long-packet payload is emitted as 32-bit

---
 rtl/camera_pkg.sv | 31 +++
 rtl/camera_lane.sv | 84 ++++++++
 rtl/camera.sv | 152 +++++++++++++++
 tb/tb_camera.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// camera_pkg: shared constants and types for the CSI-2 receiver.
//   SYNC_BYTE     lane sync byte that fixes byte alignment
//   DT_*          data-type codes; DT_SHORT_MAX is the top of the short-packet range
//   lane/packet FSM state types and header field types
package camera_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hB8;
    localparam logic [5:0] DT_SHORT_MAX     = 6'h0F;
    localparam logic [5:0] DT_GENERIC_SHORT = 6'h08;
    localparam logic [5:0] DT_YUV422_8      = 6'h1E;
    localparam logic [5:0] DT_RAW8          = 6'h2A;

    typedef logic [1:0]  vc_t;
    typedef logic [5:0]  dt_t;
    typedef logic [15:0] wc_t;

    typedef enum logic {
        LANE_HUNT,
        LANE_RECEIVE
    } lane_state_t;

    typedef enum logic {
        PKT_HEADER,
        PKT_BODY
    } pkt_state_t;

    function automatic logic is_short(input dt_t dt);
        return dt <= DT_SHORT_MAX;
    endfunction

endpackage

// File: rtl/camera_lane.sv
// camera_lane: one D-PHY data lane.
//   clock_p     DDR clock; data captured on both edges, logic on the rising edge
//   reset_in    synchronous active-high reset
//   lane_reset  one-cycle end-of-packet pulse; returns the lane to HUNT
//   data_p      serial lane data, LSB first
//   byte_data   deserialised byte (held between strobes)
//   byte_valid  one-cycle strobe per received byte
module camera_lane
    import camera_pkg::*;
(
    input  logic       clock_p,
    input  logic       reset_in,
    input  logic       lane_reset,
    input  logic       data_p,
    output logic [7:0] byte_data,
    output logic       byte_valid
);

    logic        fall_bit;
    logic [6:0]  shift_q;
    logic [8:0]  shift_next;
    lane_state_t state_q, state_n;
    logic        odd_q, odd_n;
    logic [1:0]  cyc_q, cyc_n;
    logic [7:0]  byte_n;
    logic        valid_n;

    // The falling-edge bit is the earlier of the two bits of each cycle.
    always_ff @(negedge clock_p) begin
        fall_bit <= data_p;
    end

    // Newest bit at the MSB: [8:1] is the window ending on the rising-edge bit,
    // [7:0] the window ending one bit earlier, so sync is found at either parity.
    assign shift_next = {data_p, fall_bit, shift_q};

    always_comb begin
        state_n = state_q;
        odd_n   = odd_q;
        cyc_n   = cyc_q;
        byte_n  = byte_data;
        valid_n = 1'b0;
        case (state_q)
            LANE_HUNT: begin
                if (shift_next[8:1] == SYNC_BYTE) begin
                    state_n = LANE_RECEIVE;
                    odd_n   = 1'b0;
                    cyc_n   = '0;
                end else if (shift_next[7:0] == SYNC_BYTE) begin
                    state_n = LANE_RECEIVE;
                    odd_n   = 1'b1;
                    cyc_n   = '0;
                end
            end
            LANE_RECEIVE: begin
                cyc_n = cyc_q + 2'd1;
                if (cyc_q == 2'd3) begin
                    valid_n = 1'b1;
                    byte_n  = odd_q ? shift_next[7:0] : shift_next[8:1];
                end
            end
            default: state_n = LANE_HUNT;
        endcase
    end

    always_ff @(posedge clock_p) begin
        if (reset_in || lane_reset) begin
            state_q    <= LANE_HUNT;
            shift_q    <= '0;
            odd_q      <= 1'b0;
            cyc_q      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_next[8:2];
            odd_q      <= odd_n;
            cyc_q      <= cyc_n;
            byte_data  <= byte_n;
            byte_valid <= valid_n;
        end
    end

endmodule

// File: rtl/camera.sv
// camera: MIPI CSI-2 D-PHY receiver core.
//   clock_p            DDR clock (single clock of the block)
//   reset_in           synchronous active-high reset
//   data_p             NUM_LANES serial data lanes
//   virtual_channel    VC of the last completed header
//   word_count         WC of the last completed header
//   image_data         payload word, [0] = earliest byte
//   image_data_type    DT of the last completed header
//   image_data_enable  one-cycle strobe: image_data valid
module camera
    import camera_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2
) (
    input  logic                 clock_p,
    input  logic                 reset_in,
    input  logic [NUM_LANES-1:0] data_p,
    output logic [1:0]           virtual_channel,
    output logic [15:0]          word_count,
    output logic [3:0][7:0]      image_data,
    output logic [5:0]           image_data_type,
    output logic                 image_data_enable
);

    localparam logic [17:0] LANES = 18'(NUM_LANES);

    logic [NUM_LANES-1:0] reset;
    logic [NUM_LANES-1:0] lane_valid;
    logic [7:0]           lane_byte [NUM_LANES];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        camera_lane u_lane (
            .clock_p    (clock_p),
            .reset_in   (reset_in),
            .lane_reset (reset[g]),
            .data_p     (data_p[g]),
            .byte_data  (lane_byte[g]),
            .byte_valid (lane_valid[g])
        );
    end

    pkt_state_t      st_q, st_n;
    logic [17:0]     pos_q, pos_n;
    logic [7:0]      di_q, di_n, wcl_q, wcl_n, wch_q, wch_n;
    logic [3:0][7:0] acc_q, acc_n, img_n;
    logic            en_n, eop_n;
    vc_t             vc_n;
    dt_t             dt_n, cur_dt;
    wc_t             wc_n, cur_wc;
    logic [17:0]     idx, total;
    logic [1:0]      slot;
    logic            beat, short_pkt;

    // Each beat carries packet bytes pos..pos+NUM_LANES-1 (lane k holds byte pos+k).
    // Header, payload and CRC are told apart by byte index, so a beat may straddle
    // the header/payload or payload/CRC boundary for any lane count.
    always_comb begin
        st_n   = st_q;
        pos_n  = pos_q;
        di_n   = di_q;
        wcl_n  = wcl_q;
        wch_n  = wch_q;
        acc_n  = acc_q;
        img_n  = image_data;
        en_n   = 1'b0;
        eop_n  = 1'b0;
        vc_n   = virtual_channel;
        dt_n   = image_data_type;
        wc_n   = word_count;
        idx    = '0;
        slot   = '0;
        // Lanes run in lockstep; requiring all of them keeps a lane that missed
        // sync from feeding bytes into the packet.
        beat   = &lane_valid;

        if (beat && st_q == PKT_HEADER) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                idx = pos_q + 18'(i);
                if (idx == 18'd0)      di_n  = lane_byte[i];
                else if (idx == 18'd1) wcl_n = lane_byte[i];
                else if (idx == 18'd2) wch_n = lane_byte[i];
            end
        end

        cur_dt    = di_n[5:0];
        cur_wc    = {wch_n, wcl_n};
        short_pkt = is_short(cur_dt);
        total     = short_pkt ? 18'd4 : 18'(cur_wc) + 18'd6;

        if (beat) begin
            if (st_q == PKT_HEADER && pos_q + LANES >= 18'd4) begin
                vc_n = di_n[7:6];
                dt_n = cur_dt;
                wc_n = cur_wc;
                st_n = PKT_BODY;
            end
            if (!short_pkt) begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    idx = pos_q + 18'(i);
                    if (idx >= 18'd4 && idx < 18'(cur_wc) + 18'd4) begin
                        // Payload starts at byte 4, so the word slot is idx mod 4.
                        slot = idx[1:0];
                        if (slot == 2'd0) acc_n = '0;
                        acc_n[slot] = lane_byte[i];
                        if (slot == 2'd3 || idx == 18'(cur_wc) + 18'd3) begin
                            img_n = acc_n;
                            en_n  = 1'b1;
                        end
                    end
                end
            end
            if (pos_q + LANES >= total) begin
                eop_n = 1'b1;
                pos_n = '0;
                st_n  = PKT_HEADER;
            end else begin
                pos_n = pos_q + LANES;
            end
        end
    end

    always_ff @(posedge clock_p) begin
        if (reset_in) begin
            st_q              <= PKT_HEADER;
            pos_q             <= '0;
            di_q              <= '0;
            wcl_q             <= '0;
            wch_q             <= '0;
            acc_q             <= '0;
            image_data        <= '0;
            image_data_enable <= 1'b0;
            virtual_channel   <= '0;
            image_data_type   <= '0;
            word_count        <= '0;
            reset             <= '0;
        end else begin
            st_q              <= st_n;
            pos_q             <= pos_n;
            di_q              <= di_n;
            wcl_q             <= wcl_n;
            wch_q             <= wch_n;
            acc_q             <= acc_n;
            image_data        <= img_n;
            image_data_enable <= en_n;
            virtual_channel   <= vc_n;
            image_data_type   <= dt_n;
            word_count        <= wc_n;
            reset             <= {NUM_LANES{eop_n}};
        end
    end

endmodule

// File: tb/tb_camera.sv
// tb_camera: self-checking bench for camera. Two instances (2 lanes and 1 lane)
// are fed serial lane streams built from byte-level packets; a packet-level model
// derives the expected header fields and payload words.
module tb_camera;

    typedef logic [7:0] bq_t[$];

    logic            clock_p = 1'b0;
    logic            rst2, rst1;
    logic [1:0]      d2;
    logic [0:0]      d1;
    logic [1:0]      vc2, vc1;
    logic [15:0]     wc2, wc1;
    logic [3:0][7:0] img2, img1;
    logic [5:0]      dt2, dt1;
    logic            en2, en1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_wc2 = '0;
    logic [15:0] exp_wc1 = '0;
    logic [31:0] got2[$];
    logic [31:0] got1[$];

    always #5 clock_p = ~clock_p;

    camera #(.NUM_LANES(2)) dut2 (
        .clock_p(clock_p), .reset_in(rst2), .data_p(d2),
        .virtual_channel(vc2), .word_count(wc2), .image_data(img2),
        .image_data_type(dt2), .image_data_enable(en2)
    );

    camera #(.NUM_LANES(1)) dut1 (
        .clock_p(clock_p), .reset_in(rst1), .data_p(d1),
        .virtual_channel(vc1), .word_count(wc1), .image_data(img1),
        .image_data_type(dt1), .image_data_enable(en1)
    );

    always @(negedge clock_p) begin
        if (en2) got2.push_back(img2);
        if (en1) got1.push_back(img1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // True if a sync byte appears anywhere before the intended one
    // (the lane's history is all zeros when hunting starts).
    function automatic bit bad_pre(input bit pre[$]);
        bit         w[$];
        logic [7:0] sb = 8'hB8;
        logic [7:0] v;
        for (int i = 0; i < 8; i++) w.push_back(1'b0);
        foreach (pre[i]) w.push_back(pre[i]);
        for (int t = 0; t < 8; t++) w.push_back(sb[t]);
        for (int j = 0; j + 8 < w.size(); j++) begin
            for (int t = 0; t < 8; t++) v[t] = w[j + t];
            if (v == 8'hB8) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bq_t make_pkt(input logic [7:0] di, input logic [15:0] wc);
        bq_t q;
        q.push_back(di);
        q.push_back(wc[7:0]);
        q.push_back(wc[15:8]);
        q.push_back(8'($urandom));
        if (di[5:0] > 6'h0F) begin
            for (int i = 0; i < int'(wc); i++) q.push_back(8'($urandom));
            q.push_back(8'($urandom));
            q.push_back(8'($urandom));
        end
        return q;
    endfunction

    // Serialise pk over the lanes of instance `which` (2 or 1): random preamble
    // of `pre` bits, sync, LSB-first bytes, then idle zeros. cut>0 stops early.
    task automatic send_packet(input int which, input bq_t pk, input int pre, input int cut);
        int         n = (which == 2) ? 2 : 1;
        int         nbytes = (pk.size() + n - 1) / n;
        int         limit;
        bit         ln0[$];
        bit         ln1[$];
        bit         s[$];
        logic [7:0] sb = 8'hB8;
        logic [7:0] v;
        if (which == 2) got2.delete(); else got1.delete();
        for (int l = 0; l < n; l++) begin
            do begin
                s.delete();
                for (int b = 0; b < pre; b++) s.push_back(1'($urandom_range(0, 1)));
            end while (bad_pre(s));
            for (int t = 0; t < 8; t++) s.push_back(sb[t]);
            for (int k = 0; k < nbytes; k++) begin
                v = (k * n + l < pk.size()) ? pk[k * n + l] : 8'h00;
                for (int t = 0; t < 8; t++) s.push_back(v[t]);
            end
            for (int t = 0; t < 16; t++) s.push_back(1'b0);
            if (s.size() % 2 != 0) s.push_back(1'b0);
            if (l == 0) ln0 = s; else ln1 = s;
        end
        limit = (cut > 0) ? cut : ln0.size();
        for (int st = 0; st < limit; st++) begin
            if (st % 2 == 0) @(posedge clock_p); else @(negedge clock_p);
            #1;
            if (which == 2) d2 = {ln1[st], ln0[st]};
            else            d1 = ln0[st];
            if (pre > 0 && st == pre - 1)
                chk("presync_wc", (which == 2) ? 32'(wc2) : 32'(wc1),
                    (which == 2) ? 32'(exp_wc2) : 32'(exp_wc1));
        end
        @(posedge clock_p);
        #1;
        d2 = '0;
        d1 = '0;
    endtask

    task automatic check_packet(input int which, input string name, input bq_t pk);
        logic [7:0]  di = pk[0];
        logic [15:0] wc = {pk[2], pk[1]};
        logic [31:0] ew[$];
        logic [31:0] w;
        logic [31:0] g[$];
        repeat (4) @(posedge clock_p);
        @(negedge clock_p);
        if (di[5:0] > 6'h0F) begin
            for (int b = 0; b < int'(wc); b += 4) begin
                w = '0;
                for (int j = 0; j < 4 && b + j < int'(wc); j++) w[8*j +: 8] = pk[4 + b + j];
                ew.push_back(w);
            end
        end
        g = (which == 2) ? got2 : got1;
        chk({name, "_vc"}, (which == 2) ? 32'(vc2) : 32'(vc1), 32'(di[7:6]));
        chk({name, "_dt"}, (which == 2) ? 32'(dt2) : 32'(dt1), 32'(di[5:0]));
        chk({name, "_wc"}, (which == 2) ? 32'(wc2) : 32'(wc1), 32'(wc));
        chk({name, "_en_idle"}, (which == 2) ? 32'(en2) : 32'(en1), 32'd0);
        chk({name, "_strobes"}, 32'(g.size()), 32'(ew.size()));
        foreach (ew[i]) if (i < g.size()) chk({name, "_word"}, g[i], ew[i]);
        if (which == 2) exp_wc2 = wc; else exp_wc1 = wc;
    endtask

    task automatic check_reset_state(input int which, input string name);
        chk({name, "_vc"},  (which == 2) ? 32'(vc2)  : 32'(vc1),  32'd0);
        chk({name, "_wc"},  (which == 2) ? 32'(wc2)  : 32'(wc1),  32'd0);
        chk({name, "_dt"},  (which == 2) ? 32'(dt2)  : 32'(dt1),  32'd0);
        chk({name, "_img"}, (which == 2) ? 32'(img2) : 32'(img1), 32'd0);
        chk({name, "_en"},  (which == 2) ? 32'(en2)  : 32'(en1),  32'd0);
    endtask

    initial begin
        bq_t         pk;
        logic [7:0]  di;
        logic [15:0] wc;
        int          pre;

        rst2 = 1'b1;
        rst1 = 1'b1;
        d2   = '0;
        d1   = '0;
        repeat (3) @(posedge clock_p);
        #1;
        rst2 = 1'b0;
        rst1 = 1'b0;
        @(negedge clock_p);
        check_reset_state(2, "reset2");
        check_reset_state(1, "reset1");

        // Short packet, 2 lanes.
        pk = '{8'h08, 8'hCE, 8'hFA, 8'h12};
        send_packet(2, pk, 0, 0);
        check_packet(2, "short", pk);

        // Long packet, 2 lanes, fixed payload.
        pk = '{8'h18, 8'h08, 8'h00, 8'hFE, 8'hAD, 8'hDE, 8'hE1, 8'hFE,
               8'h5E, 8'hEA, 8'h15, 8'h0D, 8'hD0, 8'hF0};
        send_packet(2, pk, 0, 0);
        check_packet(2, "long", pk);

        // Back-to-back random short then long.
        di = {2'($urandom), 6'($urandom_range(0, 15))};
        pk = make_pkt(di, 16'($urandom));
        send_packet(2, pk, 6, 0);
        check_packet(2, "b2b_short", pk);
        di = {2'($urandom), 6'($urandom_range(16, 63))};
        pk = make_pkt(di, 16'($urandom_range(1, 13)));
        send_packet(2, pk, 0, 0);
        check_packet(2, "b2b_long", pk);

        // Sync search at random bit offsets, odd and even.
        for (int k = 0; k < 4; k++) begin
            pre = (k % 2 == 0) ? 2 * $urandom_range(1, 10) + 1 : 2 * $urandom_range(1, 10);
            di  = {2'($urandom), 6'($urandom_range(16, 63))};
            wc  = 16'($urandom_range(0, 13));
            pk  = make_pkt(di, wc);
            send_packet(2, pk, pre, 0);
            check_packet(2, "sync", pk);
        end

        // One lane, WC=6: partial trailing word, then more packets behind the CRC.
        pk = make_pkt({2'b01, 6'h1E}, 16'd6);
        send_packet(1, pk, 5, 0);
        check_packet(1, "odd_wc", pk);
        pk = make_pkt({2'($urandom), 6'($urandom_range(0, 15))}, 16'($urandom));
        send_packet(1, pk, 0, 0);
        check_packet(1, "n1_short", pk);
        pk = make_pkt({2'($urandom), 6'($urandom_range(16, 63))}, 16'($urandom_range(0, 11)));
        send_packet(1, pk, 3, 0);
        check_packet(1, "n1_long", pk);

        // reset_in mid-payload, after the first word has been strobed.
        pk = make_pkt({2'b10, 6'h2A}, 16'd12);
        send_packet(2, pk, 3, 3 + 8 + 32 + 5);
        @(posedge clock_p);
        #1;
        rst2 = 1'b1;
        @(posedge clock_p);
        #1;
        rst2 = 1'b0;
        @(negedge clock_p);
        check_reset_state(2, "midreset");
        exp_wc2 = '0;
        pk = make_pkt({2'($urandom), 6'($urandom_range(16, 63))}, 16'($urandom_range(1, 13)));
        send_packet(2, pk, 7, 0);
        check_packet(2, "after_reset", pk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
